pipelined_cpu_core: RTL and testbench

Parametrised five-stage (IF/ID/EX/MEM/WB) MIPS-subset core: the next generation of the team's pipelined CPU. It adds a reset, internal memories of configurable depth, a program-load port, and a selectable forwarding mode. It also adds an extended ALU, halt detection, a retired-instruction counter and a register debug port. It is the CPU block instantiated by the lab top level and exercised directly by the ISA benches.

---
 rtl/pipelined_cpu_core.sv | 236 +++++++++++++++++++++++
 tb/tb_pipelined_cpu_core.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cpu_core.sv
// pipelined_cpu_core: five-stage (IF/ID/EX/MEM/WB) MIPS-subset core with
// internal instruction/data memories, a program-load port, optional operand
// forwarding, halt detection, a retired-instruction counter and a debug
// register read port.
module pipelined_cpu_core #(
    parameter int          IMEM_WORDS     = 1024,
    parameter int          DMEM_WORDS     = 1024,
    parameter logic [31:0] RESET_PC       = 32'd0,
    parameter bit          ENABLE_FORWARD = 1'b1,
    parameter int          CNT_W          = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_WORDS)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    input  logic [4:0]                    dbg_raddr,
    output logic [31:0]                   dbg_rdata,
    output logic [31:0]                   pc,
    output logic                          halted,
    output logic [CNT_W-1:0]              retired
);
    localparam int IA = $clog2(IMEM_WORDS);
    localparam int DA = $clog2(DMEM_WORDS);
    localparam logic [5:0] OP_R = 6'd0, OP_J = 6'd2, OP_BEQ = 6'd4, OP_BNE = 6'd5;
    localparam logic [5:0] OP_ADDI = 6'd8, OP_SLTI = 6'd10, OP_ANDI = 6'd12, OP_ORI = 6'd13;
    localparam logic [5:0] OP_LW = 6'd35, OP_SW = 6'd43, OP_HALT = 6'h3F;

    // Destination register of an instruction; 0 means "writes nothing".
    function automatic logic [4:0] f_dst(input logic [31:0] ir);
        logic [4:0] d;
        d = 5'd0;
        case (ir[31:26])
            OP_R: begin
                case (ir[5:0])
                    6'd0, 6'd2, 6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42: d = ir[15:11];
                    default: d = 5'd0;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: d = ir[20:16];
            default: d = 5'd0;
        endcase
        return d;
    endfunction

    // Whether the instruction reads rs / rt as a source operand.
    function automatic logic f_uses_rs(input logic [5:0] op);
        return (op == OP_R) || (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) ||
               (op == OP_ORI) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic f_uses_rt(input logic [5:0] op);
        return (op == OP_R) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    // Source in ID collides with a nonzero destination further down the pipe.
    function automatic logic f_hit(input logic use_rs, input logic use_rt,
                                   input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] d);
        return (d != 5'd0) && ((use_rs && (rs == d)) || (use_rt && (rt == d)));
    endfunction

    logic [31:0]      imem_q [IMEM_WORDS];
    logic [31:0]      dmem_q [DMEM_WORDS];
    logic [31:0]      rf_q [32];
    logic [31:0]      rf_d [32];
    logic [31:0]      pc_q, pc_d, ifid_ir_q, ifid_ir_d, ifid_pc4_q, ifid_pc4_d;
    logic [31:0]      idex_ir_q, idex_ir_d, idex_pc4_q, idex_pc4_d;
    logic [31:0]      idex_a_q, idex_a_d, idex_b_q, idex_b_d;
    logic [31:0]      exmem_ir_q, exmem_ir_d, exmem_res_q, exmem_res_d, exmem_sd_q, exmem_sd_d;
    logic [31:0]      memwb_ir_q, memwb_ir_d, memwb_res_q, memwb_res_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [31:0] imem_rdata, mem_rdata, id_a, id_b, ex_a, ex_b, ex_sext, ex_zext, alu;
    logic [31:0] br_target, j_target;
    logic [5:0]  id_op, idex_op, exmem_op, memwb_op;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, idex_dst, exmem_dst, memwb_dst;
    logic        id_use_rs, id_use_rt, id_stall, id_jump, ex_taken, fetch_stop;

    assign imem_rdata = imem_q[pc_q[IA+1:2]];
    assign mem_rdata  = dmem_q[exmem_res_q[DA+1:2]];
    assign id_op      = ifid_ir_q[31:26];
    assign id_rs      = ifid_ir_q[25:21];
    assign id_rt      = ifid_ir_q[20:16];
    assign idex_op    = idex_ir_q[31:26];
    assign ex_rs      = idex_ir_q[25:21];
    assign ex_rt      = idex_ir_q[20:16];
    assign exmem_op   = exmem_ir_q[31:26];
    assign memwb_op   = memwb_ir_q[31:26];
    assign idex_dst   = f_dst(idex_ir_q);
    assign exmem_dst  = f_dst(exmem_ir_q);
    assign memwb_dst  = f_dst(memwb_ir_q);
    assign id_use_rs  = f_uses_rs(id_op);
    assign id_use_rt  = f_uses_rt(id_op);
    assign id_jump    = (id_op == OP_J);
    assign j_target   = {ifid_pc4_q[31:28], ifid_ir_q[25:0], 2'b00};
    // Once a halt is decoded nothing younger may enter the pipe.
    assign fetch_stop = (id_op == OP_HALT) || (idex_op == OP_HALT) ||
                        (exmem_op == OP_HALT) || (memwb_op == OP_HALT);
    assign ex_sext    = {{16{idex_ir_q[15]}}, idex_ir_q[15:0]};
    assign ex_zext    = {16'd0, idex_ir_q[15:0]};
    assign br_target  = idex_pc4_q + {ex_sext[29:0], 2'b00};
    assign ex_taken   = ((idex_op == OP_BEQ) && (ex_a == ex_b)) || ((idex_op == OP_BNE) && (ex_a != ex_b));
    assign dbg_rdata  = rf_q[dbg_raddr];
    assign pc         = pc_q;
    assign halted     = halted_q;
    assign retired    = retired_q;

    // ID register read, bypassing the write that WB commits on this edge.
    always_comb begin
        id_a = ((memwb_dst != 5'd0) && (memwb_dst == id_rs)) ? memwb_res_q : rf_q[id_rs];
        id_b = ((memwb_dst != 5'd0) && (memwb_dst == id_rt)) ? memwb_res_q : rf_q[id_rt];
        if (ENABLE_FORWARD) begin
            id_stall = (idex_op == OP_LW) && f_hit(id_use_rs, id_use_rt, id_rs, id_rt, idex_dst);
        end else begin
            id_stall = f_hit(id_use_rs, id_use_rt, id_rs, id_rt, idex_dst) ||
                       f_hit(id_use_rs, id_use_rt, id_rs, id_rt, exmem_dst);
        end
    end

    // EX operand selection: EX/MEM result beats MEM/WB result beats latched value.
    always_comb begin
        ex_a = idex_a_q;
        ex_b = idex_b_q;
        if (ENABLE_FORWARD) begin
            if ((exmem_dst != 5'd0) && (exmem_dst == ex_rs))      ex_a = exmem_res_q;
            else if ((memwb_dst != 5'd0) && (memwb_dst == ex_rs)) ex_a = memwb_res_q;
            else                                                  ex_a = idex_a_q;
            if ((exmem_dst != 5'd0) && (exmem_dst == ex_rt))      ex_b = exmem_res_q;
            else if ((memwb_dst != 5'd0) && (memwb_dst == ex_rt)) ex_b = memwb_res_q;
            else                                                  ex_b = idex_b_q;
        end else begin
            ex_a = idex_a_q;
            ex_b = idex_b_q;
        end
    end

    // ALU: R-type functions, immediate ALU ops and load/store address generation.
    always_comb begin
        alu = 32'd0;
        case (idex_op)
            OP_R: begin
                case (idex_ir_q[5:0])
                    6'd0:    alu = ex_b << idex_ir_q[10:6];
                    6'd2:    alu = ex_b >> idex_ir_q[10:6];
                    6'd32:   alu = ex_a + ex_b;
                    6'd34:   alu = ex_a - ex_b;
                    6'd36:   alu = ex_a & ex_b;
                    6'd37:   alu = ex_a | ex_b;
                    6'd39:   alu = ~(ex_a | ex_b);
                    6'd42:   alu = {31'd0, ($signed(ex_a) < $signed(ex_b))};
                    default: alu = 32'd0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu = ex_a + ex_sext;
            OP_SLTI:               alu = {31'd0, ($signed(ex_a) < $signed(ex_sext))};
            OP_ANDI:               alu = ex_a & ex_zext;
            OP_ORI:                alu = ex_a | ex_zext;
            default:               alu = 32'd0;
        endcase
    end

    // Pipeline advance with redirect > load-use stall > jump priority; frozen once halted.
    always_comb begin
        pc_d = pc_q;             ifid_ir_d = ifid_ir_q;     ifid_pc4_d = ifid_pc4_q;
        idex_ir_d = idex_ir_q;   idex_pc4_d = idex_pc4_q;
        idex_a_d = idex_a_q;     idex_b_d = idex_b_q;
        exmem_ir_d = exmem_ir_q; exmem_res_d = exmem_res_q; exmem_sd_d = exmem_sd_q;
        memwb_ir_d = memwb_ir_q; memwb_res_d = memwb_res_q;
        halted_d = halted_q;     retired_d = retired_q;
        rf_d = rf_q;
        if (!halted_q) begin
            if (memwb_dst != 5'd0) rf_d[memwb_dst] = memwb_res_q;
            else                   rf_d[0] = 32'd0;
            halted_d  = (memwb_op == OP_HALT);
            retired_d = retired_q + (((memwb_ir_q != 32'd0) && (memwb_op != OP_HALT)) ?
                                     CNT_W'(1) : CNT_W'(0));
            memwb_ir_d  = exmem_ir_q;
            memwb_res_d = (exmem_op == OP_LW) ? mem_rdata : exmem_res_q;
            exmem_ir_d  = idex_ir_q;
            exmem_res_d = alu;
            exmem_sd_d  = ex_b;
            if (ex_taken) begin
                pc_d = br_target;
                ifid_ir_d = 32'd0;
                idex_ir_d = 32'd0;
            end else if (id_stall) begin
                idex_ir_d = 32'd0;
            end else begin
                idex_ir_d = ifid_ir_q; idex_pc4_d = ifid_pc4_q;
                idex_a_d = id_a;       idex_b_d = id_b;
                if (id_jump) begin
                    pc_d = j_target;
                    ifid_ir_d = 32'd0;
                end else if (fetch_stop) begin
                    ifid_ir_d = 32'd0;
                end else begin
                    pc_d = pc_q + 32'd4;
                    ifid_ir_d = imem_rdata;
                    ifid_pc4_d = pc_q + 32'd4;
                end
            end
        end else begin
            halted_d = 1'b1;
        end
    end

    // Architectural and pipeline state; reset returns everything to nop/zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;      ifid_ir_q <= 32'd0;   ifid_pc4_q <= 32'd0;
            idex_ir_q <= 32'd0;    idex_pc4_q <= 32'd0;  idex_a_q <= 32'd0;    idex_b_q <= 32'd0;
            exmem_ir_q <= 32'd0;   exmem_res_q <= 32'd0; exmem_sd_q <= 32'd0;
            memwb_ir_q <= 32'd0;   memwb_res_q <= 32'd0;
            halted_q <= 1'b0;      retired_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else begin
            pc_q <= pc_d;          ifid_ir_q <= ifid_ir_d;   ifid_pc4_q <= ifid_pc4_d;
            idex_ir_q <= idex_ir_d; idex_pc4_q <= idex_pc4_d; idex_a_q <= idex_a_d; idex_b_q <= idex_b_d;
            exmem_ir_q <= exmem_ir_d; exmem_res_q <= exmem_res_d; exmem_sd_q <= exmem_sd_d;
            memwb_ir_q <= memwb_ir_d; memwb_res_q <= memwb_res_d;
            halted_q <= halted_d;  retired_q <= retired_d;
            rf_q <= rf_d;
        end
    end

    // Program-load port; instruction memory is not reset.
    always_ff @(posedge clk) begin
        if (imem_we) imem_q[imem_waddr] <= imem_wdata;
    end

    // Store commit in MEM; a reset in the same cycle aborts it.
    always_ff @(posedge clk) begin
        if (!rst && !halted_q && (exmem_op == OP_SW)) dmem_q[exmem_res_q[DA+1:2]] <= exmem_sd_q;
    end
endmodule

// File: tb/tb_pipelined_cpu_core.sv
// Directed bench for pipelined_cpu_core: a forwarding instance and a
// stall-only instance run the same programs; expected register values,
// retired counts and halt edges are queued before each run and compared
// once both cores have halted.
module tb_pipelined_cpu_core;
    localparam logic [2:0] K_REG_F = 3'd0, K_REG_N = 3'd1, K_RET_F = 3'd2;
    localparam logic [2:0] K_RET_N = 3'd3, K_HLT_F = 3'd4, K_HLT_N = 3'd5;
    localparam logic [31:0] HALT = 32'hFC00_0000;

    typedef struct packed {
        logic [2:0]  kind;
        logic [4:0]  idx;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, imem_we;
    logic [9:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_f, dbg_n, pc_f, pc_n, ret_f, ret_n;
    logic        halted_f, halted_n;
    int          checks = 0, failures = 0, hf, hn;
    exp_t        sb[$];
    string       tag_q[$];
    logic [31:0] prog_q[$];

    always #5 clk = ~clk;

    pipelined_cpu_core #(.ENABLE_FORWARD(1'b1)) dut (
        .clk(clk), .rst(rst), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_f), .pc(pc_f), .halted(halted_f), .retired(ret_f));

    pipelined_cpu_core #(.ENABLE_FORWARD(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_n), .pc(pc_n), .halted(halted_n), .retired(ret_n));

    function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [2:0] kind, input logic [4:0] idx,
                           input logic [31:0] val);
        tag_q.push_back(tag);
        sb.push_back('{kind: kind, idx: idx, val: val});
    endtask

    // Hold reset, write prog_q into IMEM, then release reset on a falling edge.
    task automatic load_prog();
        @(negedge clk);
        rst = 1'b1;
        foreach (prog_q[i]) begin
            imem_we = 1'b1; imem_waddr = 10'(i); imem_wdata = prog_q[i];
            @(negedge clk);
        end
        imem_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Count rising edges after release until each core reports halted (bounded).
    task automatic run_until_halt(input int e0, output int f, output int n);
        f = -1; n = -1;
        for (int e = e0 + 1; (e <= e0 + 60) && ((f < 0) || (n < 0)); e++) begin
            @(posedge clk); @(negedge clk);
            if ((f < 0) && halted_f) f = e;
            if ((n < 0) && halted_n) n = e;
        end
    endtask

    task automatic drain(input int f, input int n);
        exp_t        e;
        string       t;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            t = tag_q.pop_front();
            dbg_raddr = e.idx;
            #1;
            case (e.kind)
                K_REG_F: obs = dbg_f;
                K_REG_N: obs = dbg_n;
                K_RET_F: obs = ret_f;
                K_RET_N: obs = ret_n;
                K_HLT_F: obs = 32'(f);
                default: obs = 32'(n);
            endcase
            check(t, obs, e.val);
        end
    endtask

    initial begin
        rst = 1'b1; imem_we = 1'b0; imem_waddr = 10'd0; imem_wdata = 32'd0; dbg_raddr = 5'd0;
        repeat (2) @(negedge clk);
        check("rst_pc", pc_f, 32'd0);
        check("rst_halted", {31'd0, halted_f}, 32'd0);
        check("rst_retired", ret_f, 32'd0);
        dbg_raddr = 5'd31; #1;
        check("rst_dbg31", dbg_f, 32'd0);

        // Forwarding chain.
        prog_q = '{ei(6'd8, 5'd0, 5'd1, 16'd5), ei(6'd8, 5'd0, 5'd2, 16'd7), er(5'd1, 5'd2, 5'd3, 6'd32), HALT};
        sb_push("fwd_r3", K_REG_F, 5'd3, 32'd12);
        sb_push("nf_r3", K_REG_N, 5'd3, 32'd12);
        sb_push("fwd_ret", K_RET_F, 5'd0, 32'd3);
        sb_push("nf_ret", K_RET_N, 5'd0, 32'd3);
        sb_push("fwd_halt_edge", K_HLT_F, 5'd0, 32'd8);
        sb_push("nf_halt_edge", K_HLT_N, 5'd0, 32'd10);
        load_prog(); run_until_halt(0, hf, hn); drain(hf, hn);

        // Load-use; the load address aliases word 1 through DMEM wrap-around.
        prog_q = '{ei(6'd8, 5'd0, 5'd1, 16'd9), ei(6'd43, 5'd0, 5'd1, 16'd4),
                   ei(6'd35, 5'd0, 5'd4, 16'h1004), er(5'd4, 5'd4, 5'd5, 6'd32), HALT};
        sb_push("lu_r4", K_REG_F, 5'd4, 32'd9);
        sb_push("lu_r5", K_REG_F, 5'd5, 32'd18);
        sb_push("lu_nf_r5", K_REG_N, 5'd5, 32'd18);
        sb_push("lu_ret", K_RET_F, 5'd0, 32'd4);
        sb_push("lu_halt_edge", K_HLT_F, 5'd0, 32'd10);
        sb_push("lu_nf_halt_edge", K_HLT_N, 5'd0, 32'd13);
        load_prog(); run_until_halt(0, hf, hn); drain(hf, hn);

        // Taken beq over two addi $6, then ori.
        prog_q = '{ei(6'd4, 5'd0, 5'd0, 16'd2), ei(6'd8, 5'd0, 5'd6, 16'd1),
                   ei(6'd8, 5'd0, 5'd6, 16'd2), ei(6'd13, 5'd0, 5'd7, 16'hFFFF), HALT};
        sb_push("br_r6", K_REG_F, 5'd6, 32'd0);
        sb_push("br_r7", K_REG_F, 5'd7, 32'h0000_FFFF);
        sb_push("br_nf_r6", K_REG_N, 5'd6, 32'd0);
        sb_push("br_ret", K_RET_F, 5'd0, 32'd2);
        sb_push("br_nf_ret", K_RET_N, 5'd0, 32'd2);
        sb_push("br_halt_edge", K_HLT_F, 5'd0, 32'd9);
        load_prog(); run_until_halt(0, hf, hn); drain(hf, hn);

        // Jump, write to $0, signed slt with negative operand.
        prog_q = '{ei(6'd8, 5'd0, 5'd0, 16'd7), ei(6'd8, 5'd0, 5'd8, 16'hFFFD), {6'd2, 26'd5},
                   ei(6'd8, 5'd0, 5'd9, 16'd1), ei(6'd8, 5'd0, 5'd9, 16'd2),
                   er(5'd8, 5'd0, 5'd10, 6'd42), HALT};
        sb_push("j_r0", K_REG_F, 5'd0, 32'd0);
        sb_push("j_r8", K_REG_F, 5'd8, 32'hFFFF_FFFD);
        sb_push("j_r9", K_REG_F, 5'd9, 32'd0);
        sb_push("j_slt", K_REG_F, 5'd10, 32'd1);
        sb_push("j_nf_slt", K_REG_N, 5'd10, 32'd1);
        sb_push("j_ret", K_RET_F, 5'd0, 32'd4);
        sb_push("j_halt_edge", K_HLT_F, 5'd0, 32'd10);
        sb_push("j_nf_halt_edge", K_HLT_N, 5'd0, 32'd10);
        load_prog(); run_until_halt(0, hf, hn); drain(hf, hn);

        // Mid-run reset of the same program, then restart from RESET_PC.
        load_prog();
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("mid_ret_before_rst", ret_f, 32'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_pc", pc_f, 32'd0);
        check("mid_rst_nf_pc", pc_n, 32'd0);
        check("mid_rst_halted", {31'd0, halted_f}, 32'd0);
        check("mid_rst_ret", ret_f, 32'd0);
        check("mid_rst_nf_ret", ret_n, 32'd0);
        for (int r = 0; r < 32; r++) begin
            dbg_raddr = 5'(r);
            #1;
            check($sformatf("mid_rst_reg%0d", r), dbg_f, 32'd0);
            check($sformatf("mid_rst_nf_reg%0d", r), dbg_n, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("restart_pc", pc_f, 32'd4);
        check("restart_nf_pc", pc_n, 32'd4);
        sb_push("restart_slt", K_REG_F, 5'd10, 32'd1);
        sb_push("restart_ret", K_RET_F, 5'd0, 32'd4);
        sb_push("restart_halt_edge", K_HLT_F, 5'd0, 32'd10);
        run_until_halt(1, hf, hn); drain(hf, hn);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
